// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter.
//   state_e         : measurement FSM encoding (IDLE, ARM, MEAS)
//   DEFAULT_TIMEOUT : default stuck-input limit in clk cycles
package clk_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_TIMEOUT = 2000000;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer with edge detection for an asynchronous input.
// Usable for any slow asynchronous level (buttons, divided clocks, ticks).
// Ports:
//   clk      : sampling clock
//   rst      : asynchronous active-high reset, clears every flop
//   d_async  : asynchronous input
//   rise     : high for one cycle after the synchronized level goes 0->1
//   fall     : high for one cycle after the synchronized level goes 1->0
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   hist_q;
   logic                   hist_d;
   logic                   s;

   // The last synchronizer stage is the settled level; hist keeps its
   // previous value so edges are visible for exactly one cycle.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
      s      = sync_q[SYNC_STAGES-1];
      hist_d = s;
      rise   = s & ~hist_q;
      fall   = ~s & hist_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   en           : measurement enable, low returns the meter to IDLE
//   sig_in       : asynchronous input being measured
//   rise_pulse   : one-cycle pulse per synchronized rising edge (ungated)
//   period       : last measured rise-to-rise distance
//   high_time    : rise-to-fall distance inside that same period
//   period_valid : one-cycle pulse when period/high_time update
//   timeout      : sticky, set after TIMEOUT cycles without a rising edge
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic             rise_pulse,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic             rise;
   logic             fall;

   state_e           state_q,        state_d;
   logic [CNT_W-1:0] cnt_q,          cnt_d;
   logic [CNT_W-1:0] hi_cap_q,       hi_cap_d;
   logic [CNT_W-1:0] period_q,       period_d;
   logic [CNT_W-1:0] high_time_q,    high_time_d;
   logic             period_valid_q, period_valid_d;
   logic             timeout_q,      timeout_d;
   logic             rise_pulse_q,   rise_pulse_d;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_async (sig_in),
      .rise    (rise),
      .fall    (fall)
   );

   // Next-state logic. Priority is en, then rise, then timeout, then count.
   // A rise landing on the cycle cnt reaches TIMEOUT is a valid measurement.
   // cnt restarts at 1 on a rise so that the following rise P cycles later
   // samples cnt==P.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hi_cap_d       = hi_cap_q;
      period_d       = period_q;
      high_time_d    = high_time_q;
      timeout_d      = timeout_q;
      period_valid_d = 1'b0;
      rise_pulse_d   = rise;

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end

            // First rise only establishes the phase; nothing is reported yet.
            ARM: begin
               if (rise) begin
                  cnt_d   = CNT_ONE;
                  state_d = MEAS;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            MEAS: begin
               if (fall) begin
                  hi_cap_d = cnt_q;
               end
               if (rise) begin
                  period_d       = cnt_q;
                  high_time_d    = hi_cap_q;
                  period_valid_d = 1'b1;
                  timeout_d      = 1'b0;
                  cnt_d          = CNT_ONE;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ARM;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         hi_cap_q       <= '0;
         period_q       <= '0;
         high_time_q    <= '0;
         period_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         rise_pulse_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         hi_cap_q       <= hi_cap_d;
         period_q       <= period_d;
         high_time_q    <= high_time_d;
         period_valid_q <= period_valid_d;
         timeout_q      <= timeout_d;
         rise_pulse_q   <= rise_pulse_d;
      end
   end

   assign rise_pulse   = rise_pulse_q;
   assign period       = period_q;
   assign high_time    = high_time_q;
   assign period_valid = period_valid_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter.
// Main instance uses TIMEOUT=50; a second instance with TIMEOUT=20 covers a
// rise arriving exactly on the timeout cycle.
module tb_clk_period_meter;

   localparam int CNT_W = 32;

   typedef struct {
      logic [CNT_W-1:0] per;
      logic [CNT_W-1:0] hi;
   } meas_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             sig_in = 1'b0;
   logic             rise_pulse;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             timeout;

   logic             en_b = 1'b0;
   logic             sig_b = 1'b0;
   logic             rise_pulse_b;
   logic [CNT_W-1:0] period_b;
   logic [CNT_W-1:0] high_time_b;
   logic             period_valid_b;
   logic             timeout_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   meas_t            exp_q[$];
   int               rise_q[$];
   logic [CNT_W-1:0] hold_p = '0;
   logic [CNT_W-1:0] hold_h = '0;

   bit               model_meas = 1'b0;
   int               last_p = 0;
   int               last_h = 0;

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2),
      .TIMEOUT     (50)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sig_in       (sig_in),
      .rise_pulse   (rise_pulse),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .timeout      (timeout)
   );

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2),
      .TIMEOUT     (20)
   ) dut_b (
      .clk          (clk),
      .rst          (rst),
      .en           (en_b),
      .sig_in       (sig_b),
      .rise_pulse   (rise_pulse_b),
      .period       (period_b),
      .high_time    (high_time_b),
      .period_valid (period_valid_b),
      .timeout      (timeout_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record the cycle of every driven rising edge for the latency check.
   always @(posedge sig_in) rise_q.push_back(cyc);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on every valid, otherwise outputs must hold.
   always @(negedge clk) begin
      if (rst) begin
         hold_p = '0;
         hold_h = '0;
      end else if (period_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", period_valid, 0);
         end else begin
            meas_t m;
            m = exp_q.pop_front();
            checkOutput("period", period, m.per);
            checkOutput("high_time", high_time, m.hi);
            hold_p = m.per;
            hold_h = m.hi;
         end
      end else begin
         checkOutput("period_hold", period, hold_p);
         checkOutput("high_time_hold", high_time, hold_h);
      end
   end

   // rise_pulse must trail each driven rise by three clk edges.
   always @(negedge clk) begin
      if (!rst && rise_pulse) begin
         if (rise_q.size() == 0) begin
            checkOutput("unexpected_rise_pulse", rise_pulse, 0);
         end else begin
            checkOutput("rise_lag", cyc - rise_q.pop_front(), 3);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // One period of the main input: h cycles high, l cycles low.
   task automatic applyStimulus(input int h, input int l);
      if (model_meas) exp_q.push_back('{CNT_W'(last_p), CNT_W'(last_h)});
      model_meas = 1'b1;
      sig_in = 1'b1;
      step(h);
      sig_in = 1'b0;
      step(l);
      last_p = h + l;
      last_h = h;
   endtask

   // One 20-cycle period (10 high) on the TIMEOUT=20 instance.
   task automatic applyStimulusB(input bit expect_valid);
      sig_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("b_valid", period_valid_b, expect_valid);
      if (expect_valid) begin
         checkOutput("b_period", period_b, 20);
         checkOutput("b_high_time", high_time_b, 10);
      end
      checkOutput("b_timeout", timeout_b, 0);
      @(posedge clk);
      #2;
      step(6);
      sig_b = 1'b0;
      step(10);
   endtask

   initial begin
      int n;
      $display("[TB] start");

      // Reset state
      step(3);
      checkOutput("rst_rise_pulse", rise_pulse, 0);
      checkOutput("rst_period", period, 0);
      checkOutput("rst_high_time", high_time, 0);
      checkOutput("rst_valid", period_valid, 0);
      checkOutput("rst_timeout", timeout, 0);
      rst = 1'b0;
      en  = 1'b1;
      step(2);

      // 5/5 square wave, then duty change to 3/9
      repeat (4) applyStimulus(5, 5);
      repeat (2) applyStimulus(3, 9);

      // Final rise reports 12/3, then input stays low until timeout
      exp_q.push_back('{CNT_W'(last_p), CNT_W'(last_h)});
      sig_in = 1'b1;
      step(3);
      sig_in = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rise_pulse && n < 20);
      checkOutput("to_pulse_seen", rise_pulse, 1);
      checkOutput("to_flag_before", timeout, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout && n < 200);
      checkOutput("to_delay", n, 50);
      checkOutput("to_flag", timeout, 1);
      model_meas = 1'b0;
      @(posedge clk);
      #2;

      // First rise re-arms only, second one clears timeout
      applyStimulus(5, 5);
      checkOutput("to_after_rearm", timeout, 1);
      applyStimulus(5, 5);
      checkOutput("to_cleared", timeout, 0);

      // en dropped mid-period, a rise while disabled, then restored
      exp_q.push_back('{CNT_W'(last_p), CNT_W'(last_h)});
      sig_in = 1'b1;
      step(5);
      sig_in = 1'b0;
      step(2);
      en = 1'b0;
      step(3);
      sig_in = 1'b1;
      step(5);
      sig_in = 1'b0;
      step(5);
      checkOutput("en_off_period", period, 10);
      checkOutput("en_off_high_time", high_time, 5);
      en = 1'b1;
      step(3);
      model_meas = 1'b0;
      applyStimulus(5, 5);
      applyStimulus(5, 5);

      // Asynchronous reset in the low phase of a measurement
      exp_q.push_back('{CNT_W'(last_p), CNT_W'(last_h)});
      sig_in = 1'b1;
      step(5);
      sig_in = 1'b0;
      step(2);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst_period", period, 0);
      checkOutput("arst_high_time", high_time, 0);
      checkOutput("arst_valid", period_valid, 0);
      checkOutput("arst_timeout", timeout, 0);
      checkOutput("arst_rise_pulse", rise_pulse, 0);
      model_meas = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #4 rst = 1'b0;
      @(posedge clk);
      #2;
      repeat (3) applyStimulus(4, 6);

      // Rise exactly on the timeout cycle (TIMEOUT=20, period 20)
      en_b = 1'b1;
      step(2);
      applyStimulusB(1'b0);
      repeat (3) applyStimulusB(1'b1);
      step(2);
      checkOutput("b_to_edge_minus1", timeout_b, 0);
      step(1);
      checkOutput("b_to_edge", timeout_b, 1);

      checkOutput("sb_empty", exp_q.size(), 0);
      checkOutput("rise_q_empty", rise_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
